rtc_bus_mux: RTL and testbench



---
 rtl/rtc_bus_mux.sv | 129 ++++++++++++
 tb/tb_rtc_bus_mux.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_bus_mux.sv
// RTC bus data selector and drive sequencer.
// Picks one of N write-data channels, or captures RTC read data, into a
// registered data_save word. It also sequences the drive/hold/turnaround
// window that gates the bidirectional data pins.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | bus released, waiting for wr_req / rd_req
// WRITE | FPGA drives data_save onto the bus for HOLD_CYC cycles
// READ  | bus released, rd_data sampled on the last of HOLD_CYC cycles
// TURN  | one-cycle turnaround, done pulses, no requests accepted
module rtc_bus_mux #(
  parameter int W        = 8,
  parameter int N        = 4,
  parameter int SELW     = 2,
  parameter int HOLD_CYC = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N*W-1:0]  wr_src,
  input  logic [SELW-1:0] wr_sel,
  input  logic            wr_req,
  input  logic            rd_req,
  input  logic [W-1:0]    rd_data,
  output logic [W-1:0]    data_save,
  output logic            drive_en,
  output logic            busy,
  output logic            done,
  output logic            err
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, TURN} state_t;

  localparam int               CW       = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [CW-1:0]    CNT_LAST = CW'(HOLD_CYC - 1);
  localparam int               NSEL     = 1 << SELW;
  localparam logic [SELW:0]    N_SEL    = (SELW + 1)'(N);

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [W-1:0]  data_d;
  logic          err_d;
  logic          sel_ok;
  logic [W-1:0]  ch [NSEL];

  // Unpack the flattened sources; selects beyond N read as zero and are
  // rejected anyway, so the mux never indexes past the array.
  for (genvar k = 0; k < NSEL; k++) begin : g_ch
    if (k < N) begin : g_real
      assign ch[k] = wr_src[k*W +: W];
    end else begin : g_pad
      assign ch[k] = '0;
    end
  end

  assign sel_ok = ({1'b0, wr_sel} < N_SEL);

  // Next-state, hold counter and data capture decisions.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    data_d  = data_save;
    err_d   = 1'b0;
    case (state)
      IDLE: begin
        if (wr_req) begin
          if (sel_ok) begin
            data_d  = ch[wr_sel];
            cnt_d   = '0;
            state_d = WRITE;
          end else begin
            err_d = 1'b1;
          end
        end else if (rd_req) begin
          cnt_d   = '0;
          state_d = READ;
        end
      end
      WRITE: begin
        if (cnt == CNT_LAST) begin
          cnt_d   = '0;
          state_d = TURN;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      READ: begin
        if (cnt == CNT_LAST) begin
          data_d  = rd_data;
          cnt_d   = '0;
          state_d = TURN;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      TURN: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State register; outputs are decoded from the next state so they are
  // registered and aligned with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      data_save <= '0;
      drive_en  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      data_save <= data_d;
      drive_en  <= (state_d == WRITE);
      busy      <= (state_d != IDLE);
      done      <= (state_d == TURN);
      err       <= err_d;
    end
  end

endmodule

// File: tb/tb_rtc_bus_mux.sv
// Directed bench for rtc_bus_mux (W=8, N=4, HOLD_CYC=2), plus a second
// instance with N=3 so an out-of-range select can be exercised.
module tb_rtc_bus_mux;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] wr_src;
  logic [1:0]  wr_sel;
  logic        wr_req, rd_req;
  logic [7:0]  rd_data;
  logic [7:0]  data_save, e_data_save;
  logic        drive_en, busy, done, err;
  logic        e_drive_en, e_busy, e_done, e_err;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  rtc_bus_mux #(.W(8), .N(4), .SELW(2), .HOLD_CYC(2)) dut (
    .clk(clk), .reset(reset), .wr_src(wr_src), .wr_sel(wr_sel),
    .wr_req(wr_req), .rd_req(rd_req), .rd_data(rd_data),
    .data_save(data_save), .drive_en(drive_en), .busy(busy),
    .done(done), .err(err)
  );

  rtc_bus_mux #(.W(8), .N(3), .SELW(2), .HOLD_CYC(2)) dut_n3 (
    .clk(clk), .reset(reset), .wr_src(wr_src[23:0]), .wr_sel(wr_sel),
    .wr_req(wr_req), .rd_req(rd_req), .rd_data(rd_data),
    .data_save(e_data_save), .drive_en(e_drive_en), .busy(e_busy),
    .done(e_done), .err(e_err)
  );

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    wr_src  = $urandom;
    wr_sel  = 2'($urandom_range(0, 3));
    wr_req  = 1'($urandom_range(0, 1));
    rd_req  = 1'($urandom_range(0, 1));
    rd_data = 8'($urandom);
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({data_save, drive_en, busy, done, err} !== 12'h000) begin
        failures++;
        $display("FAIL reset_outputs cyc=%0d got=%h want=000", i,
                 {data_save, drive_en, busy, done, err});
      end
    end
    reset = 1'b0; wr_req = 1'b0; rd_req = 1'b0; rd_data = 8'h00;
    wr_src = {8'h59, 8'h23, 8'h12, 8'h07};
    tick();
    checks++;
    if (busy !== 1'b0 || data_save !== 8'h00) begin
      failures++;
      $display("FAIL reset_idle busy=%b data=%h want busy=0 data=00", busy, data_save);
    end
  endtask

  task automatic test_write_ch2();
    wr_sel = 2'd2; wr_req = 1'b1;
    tick();                       // cycle 1
    wr_req = 1'b0;
    checks++;
    if (drive_en !== 1'b1 || data_save !== 8'h23 || busy !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL write_c1 de=%b data=%h busy=%b done=%b want 1 23 1 0",
               drive_en, data_save, busy, done);
    end
    wr_src = 32'hAABBCCDD; wr_sel = 2'd1;
    tick();                       // cycle 2
    checks++;
    if (drive_en !== 1'b1 || data_save !== 8'h23 || done !== 1'b0) begin
      failures++;
      $display("FAIL write_c2 de=%b data=%h done=%b want 1 23 0", drive_en, data_save, done);
    end
    tick();                       // cycle 3: TURN
    checks++;
    if (drive_en !== 1'b0 || done !== 1'b1 || busy !== 1'b1 || data_save !== 8'h23) begin
      failures++;
      $display("FAIL write_turn de=%b done=%b busy=%b data=%h want 0 1 1 23",
               drive_en, done, busy, data_save);
    end
    tick();                       // cycle 4: IDLE
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || drive_en !== 1'b0) begin
      failures++;
      $display("FAIL write_idle busy=%b done=%b de=%b want 0 0 0", busy, done, drive_en);
    end
    wr_src = {8'h59, 8'h23, 8'h12, 8'h07};
  endtask

  task automatic test_read();
    rd_data = 8'h00; rd_req = 1'b1;
    tick();                       // cycle 1
    rd_req = 1'b0;
    checks++;
    if (busy !== 1'b1 || drive_en !== 1'b0 || data_save !== 8'h23) begin
      failures++;
      $display("FAIL read_c1 busy=%b de=%b data=%h want 1 0 23", busy, drive_en, data_save);
    end
    tick();                       // cycle 2
    checks++;
    if (drive_en !== 1'b0 || data_save !== 8'h23 || done !== 1'b0) begin
      failures++;
      $display("FAIL read_c2 de=%b data=%h done=%b want 0 23 0", drive_en, data_save, done);
    end
    rd_data = 8'h45;
    tick();                       // cycle 3
    rd_data = 8'h00;
    checks++;
    if (data_save !== 8'h45 || done !== 1'b1 || drive_en !== 1'b0) begin
      failures++;
      $display("FAIL read_capture data=%h done=%b de=%b want 45 1 0", data_save, done, drive_en);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || data_save !== 8'h45) begin
      failures++;
      $display("FAIL read_idle busy=%b data=%h want 0 45", busy, data_save);
    end
  endtask

  task automatic test_simultaneous();
    wr_sel = 2'd0; wr_req = 1'b1; rd_req = 1'b1;
    tick();
    wr_req = 1'b0; rd_req = 1'b0;
    checks++;
    if (drive_en !== 1'b1 || data_save !== 8'h07) begin
      failures++;
      $display("FAIL simul_write de=%b data=%h want 1 07", drive_en, data_save);
    end
    tick(); tick();
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL simul_done done=%b want 1", done);
    end
    tick(); tick();
    checks++;
    if (busy !== 1'b0 || data_save !== 8'h07) begin
      failures++;
      $display("FAIL simul_no_read busy=%b data=%h want 0 07", busy, data_save);
    end
  endtask

  task automatic test_err();
    wr_sel = 2'd3; wr_req = 1'b1; rd_req = 1'b1;
    tick();
    wr_req = 1'b0; rd_req = 1'b0;
    checks++;
    if (e_err !== 1'b1 || e_busy !== 1'b0 || e_data_save !== 8'h07) begin
      failures++;
      $display("FAIL err_pulse err=%b busy=%b data=%h want 1 0 07", e_err, e_busy, e_data_save);
    end
    checks++;
    if (err !== 1'b0 || data_save !== 8'h59) begin
      failures++;
      $display("FAIL err_n4_write err=%b data=%h want 0 59", err, data_save);
    end
    tick();
    checks++;
    if (e_err !== 1'b0 || e_busy !== 1'b0) begin
      failures++;
      $display("FAIL err_one_cycle err=%b busy=%b want 0 0", e_err, e_busy);
    end
    tick(); tick(); tick();
  endtask

  task automatic test_busy_ignore();
    int n_done = 0;
    wr_sel = 2'd1; wr_req = 1'b1;
    tick();                       // cycle 1
    wr_req = 1'b0; rd_req = 1'b1;
    tick();                       // cycle 2
    rd_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (done === 1'b1) n_done++;
      tick();
    end
    checks++;
    if (n_done != 1 || busy !== 1'b0 || data_save !== 8'h12) begin
      failures++;
      $display("FAIL busy_ignore dones=%0d busy=%b data=%h want 1 0 12", n_done, busy, data_save);
    end
  endtask

  task automatic test_back_to_back();
    logic exp_done, exp_busy;
    wr_sel = 2'd3; wr_req = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      exp_done = (i % 4 == 3);
      exp_busy = (i % 4 != 0);
      checks++;
      if (done !== exp_done || busy !== exp_busy) begin
        failures++;
        $display("FAIL back_to_back cyc=%0d done=%b busy=%b want %b %b",
                 i, done, busy, exp_done, exp_busy);
      end
    end
    wr_req = 1'b0;
    tick(); tick();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL back_to_back_stop busy=%b want 0", busy);
    end
  endtask

  task automatic test_reset_mid_write();
    int n_done = 0;
    wr_sel = 2'd2; wr_req = 1'b1;
    tick();                       // cycle 1
    wr_req = 1'b0;
    checks++;
    if (drive_en !== 1'b1 || data_save !== 8'h23) begin
      failures++;
      $display("FAIL midrst_start de=%b data=%h want 1 23", drive_en, data_save);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (drive_en !== 1'b0 || data_save !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL midrst_abort de=%b data=%h busy=%b done=%b want 0 00 0 0",
               drive_en, data_save, busy, done);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) n_done++;
    end
    checks++;
    if (n_done != 0) begin
      failures++;
      $display("FAIL midrst_quiet activity_cycles=%0d want 0", n_done);
    end
  endtask

  initial begin
    test_reset();
    test_write_ch2();
    test_read();
    test_simultaneous();
    test_err();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid_write();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
